button_debouncer: RTL and testbench

- Upstream front-end for the LED comparator stage.
- Takes raw, bouncing, asynchronous push-button inputs and synchronises them into the clock domain.
- Filters out contact bounce and drives clean, stable button levels plus single-cycle press/release pulses.
- Its btn_level outputs drive the comparator's button1/button2 inputs directly.

---
 rtl/btn_pkg.sv | 15 +
 rtl/debounce_channel.sv | 76 +++++++
 rtl/button_debouncer.sv | 39 +++
 tb/tb_button_debouncer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button debouncer.
//   DEBOUNCE_CYCLES_DEF : default settle time in clk cycles (20 ms at 50 MHz)
//   SYNC_STAGES_DEF     : default synchroniser depth
//   cnt_width()         : debounce counter width for a given settle time
package btn_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int unsigned SYNC_STAGES_DEF     = 2;

  // Counter must hold values up to DEBOUNCE_CYCLES; never less than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button channel: synchroniser, settle counter, stable level
// register and registered press/release pulses.
// Build option: BTN_ACTIVE_LOW_EN inverts the raw pin ahead of the
// synchroniser so a low (pressed) pin reads as 1 downstream.
// Ports:
//   i_clk     : system clock, rising edge
//   i_rst     : asynchronous active-high reset
//   i_raw     : raw button pin, asynchronous to i_clk
//   o_level   : debounced level
//   o_press   : one-cycle pulse when o_level goes 0->1
//   o_release : one-cycle pulse when o_level goes 1->0
module debounce_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   w_in;
  logic                   w_sync;
  logic                   w_diff;
  logic                   w_accept;

`ifdef BTN_ACTIVE_LOW_EN
  assign w_in = ~i_raw;
`else
  assign w_in = i_raw;
`endif

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_diff   = (w_sync != r_level);
  // Accept on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], w_in};
      r_press   <= w_accept &  w_sync;
      r_release <= w_accept & ~w_sync;
      if (w_accept) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt   <= '0;
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: one independent debounce_channel per
// button. Build option BTN_ACTIVE_LOW_EN selects active-low button pins.
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   btn_raw     : raw button pins, asynchronous to clk
//   btn_level   : debounced button levels (registered)
//   btn_press   : one-cycle pulse per channel on 0->1 of btn_level
//   btn_release : one-cycle pulse per channel on 1->0 of btn_level
module button_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release
);

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_raw     (btn_raw[gi]),
      .o_level   (btn_level[gi]),
      .o_press   (btn_press[gi]),
      .o_release (btn_release[gi])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (N_BUTTONS=2, DEBOUNCE_CYCLES=8,
// SYNC_STAGES=2). Stimulus is written in logical "pressed" terms; the drive
// task maps it onto pin polarity for the BTN_ACTIVE_LOW_EN build.
// Expected press/release events are queued with their due cycle when the
// stimulus is applied and consumed by a per-cycle monitor.
module tb_button_debouncer;

  localparam int unsigned LAT = 10;  // SYNC_STAGES + DEBOUNCE_CYCLES

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  typedef struct {
    int unsigned cyc;
    int unsigned ch;
    bit          press;
  } ev_t;

  ev_t         exp_q[$];
  logic [1:0]  exp_level;
  logic [1:0]  exp_press;
  logic [1:0]  exp_release;
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          mon_en = 1'b0;

  button_debouncer #(
    .N_BUTTONS       (2),
    .DEBOUNCE_CYCLES (8),
    .SYNC_STAGES     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] pressed);
`ifdef BTN_ACTIVE_LOW_EN
    btn_raw = ~pressed;
`else
    btn_raw = pressed;
`endif
  endtask

  task automatic expect_ev(input int unsigned ch, input bit press);
    exp_q.push_back('{cyc: cyc + LAT, ch: ch, press: press});
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle scoreboard check, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_press   = '0;
      exp_release = '0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        ev_t ev;
        ev = exp_q.pop_front();
        if (ev.cyc != cyc) begin
          checks++;
          errors++;
          $error("FAIL stale_event cyc=%0d got=none exp=event@%0d", cyc, ev.cyc);
        end
        if (ev.press) begin
          exp_press[ev.ch]   = 1'b1;
          exp_level[ev.ch]   = 1'b1;
        end else begin
          exp_release[ev.ch] = 1'b1;
          exp_level[ev.ch]   = 1'b0;
        end
      end
      check("press",   btn_press,   exp_press);
      check("release", btn_release, exp_release);
      check("level",   btn_level,   exp_level);
    end
  end

  initial begin
    // Reset state
    rst = 1'b1;
    drive(2'b00);
    exp_level = '0;
    cycles(3);
    check("rst_level",   btn_level,   2'b00);
    check("rst_press",   btn_press,   2'b00);
    check("rst_release", btn_release, 2'b00);
    rst    = 1'b0;
    mon_en = 1'b1;
    cycles(12);

    // Clean press on channel 0
    drive(2'b01);
    expect_ev(0, 1'b1);
    cycles(15);

    // Channel 1 bounce: 3-cycle highs/lows, then held high
    for (int unsigned k = 0; k < 2; k++) begin
      drive(2'b11);
      cycles(3);
      drive(2'b01);
      cycles(3);
    end
    drive(2'b11);
    expect_ev(1, 1'b1);
    cycles(15);

    // Channel 0 glitch low for 7 cycles: discarded
    drive(2'b10);
    cycles(7);
    drive(2'b11);
    cycles(12);
    // Channel 0 held low: release
    drive(2'b10);
    expect_ev(0, 1'b0);
    cycles(15);

    // Both channels change on the same cycle
    drive(2'b01);
    expect_ev(0, 1'b1);
    expect_ev(1, 1'b0);
    cycles(15);
    drive(2'b11);
    expect_ev(1, 1'b1);
    cycles(15);

    // Asynchronous reset mid-cycle with both levels high
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("async_rst_level",   btn_level,   2'b00);
    check("async_rst_press",   btn_press,   2'b00);
    check("async_rst_release", btn_release, 2'b00);
    exp_q.delete();
    exp_level = '0;
    drive(2'b00);
    cycles(3);
    rst    = 1'b0;
    mon_en = 1'b1;
    cycles(5);

    // Reset during counting: partial count lost, press after full latency
    drive(2'b01);
    expect_ev(0, 1'b1);
    cycles(8);
    mon_en = 1'b0;
    rst    = 1'b1;
    exp_q.delete();
    exp_level = '0;
    cycles(2);
    check("midcount_rst_level", btn_level, 2'b00);
    rst    = 1'b0;
    mon_en = 1'b1;
    expect_ev(0, 1'b1);
    cycles(15);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL pending_events got=%0d exp=0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
